// File: rtl/reg16_bus_master_if.sv
// rtl/reg16_bus_master_if.sv - command/response port and chip-select register bus
interface reg16_bus_master_if #(
  parameter int NREG = 3,
  parameter int AW   = 2,
  parameter int DW   = 16
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_wr;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [DW-1:0]   bus_din;
  logic [NREG-1:0] bus_cs;
  logic            bus_w;
  logic            bus_r;
  logic [DW-1:0]   bus_dout;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, bus_dout,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_din, bus_cs, bus_w, bus_r
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, bus_dout,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_din, bus_cs, bus_w, bus_r
  );
endinterface

// File: rtl/reg16_bus_master.sv
// rtl/reg16_bus_master.sv - single-command initiator for the chip-select register bus
module reg16_bus_master #(
  parameter int NREG = 3,
  parameter int AW   = 2,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  reg16_bus_master_if.master bus,
  output logic [15:0]        txn_count
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, RESP} state_t;

  localparam logic [AW:0]     NREG_W = (AW+1)'(NREG);
  localparam logic [NREG-1:0] CS_ONE = NREG'(1);

  state_t          state, state_d;
  logic            wr_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            accept, bad_addr, rsp_hs;
  logic            wr_n;
  logic [AW-1:0]   addr_n;
  logic [DW-1:0]   wdata_n;
  logic            cmd_ready_d, rsp_valid_d, rsp_err_d, bus_w_d, bus_r_d;
  logic [DW-1:0]   rsp_rdata_d, bus_din_d;
  logic [NREG-1:0] bus_cs_d;

  assign accept   = (state == IDLE) && bus.cmd_valid;
  assign bad_addr = {1'b0, bus.cmd_addr} >= NREG_W;
  assign rsp_hs   = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_d = bad_addr ? RESP : SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so every port comes straight from a flop.
  always_comb begin
    wr_n        = accept ? bus.cmd_wr    : wr_q;
    addr_n      = accept ? bus.cmd_addr  : addr_q;
    wdata_n     = accept ? bus.cmd_wdata : wdata_q;
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    bus_cs_d    = '0;
    bus_din_d   = '0;
    bus_w_d     = 1'b0;
    bus_r_d     = 1'b0;
    if (state_d inside {SETUP, ACCESS, CAPTURE}) begin
      bus_cs_d  = CS_ONE << addr_n;
      bus_din_d = wr_n ? wdata_n : '0;
    end
    if (state_d == ACCESS) begin
      bus_w_d = wr_n;
      bus_r_d = !wr_n;
    end
    rsp_err_d   = bus.rsp_err;
    rsp_rdata_d = bus.rsp_rdata;
    if (accept) begin
      rsp_err_d   = bad_addr;
      rsp_rdata_d = '0;
    end else if (state == CAPTURE && !wr_q) begin
      rsp_rdata_d = bus.bus_dout;
    end else if (rsp_hs) begin
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= bus.cmd_wr;
      addr_q  <= bus.cmd_addr;
      wdata_q <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.bus_din   <= '0;
      bus.bus_cs    <= '0;
      bus.bus_w     <= 1'b0;
      bus.bus_r     <= 1'b0;
      txn_count     <= '0;
    end else begin
      bus.cmd_ready <= cmd_ready_d;
      bus.rsp_valid <= rsp_valid_d;
      bus.rsp_rdata <= rsp_rdata_d;
      bus.rsp_err   <= rsp_err_d;
      bus.bus_din   <= bus_din_d;
      bus.bus_cs    <= bus_cs_d;
      bus.bus_w     <= bus_w_d;
      bus.bus_r     <= bus_r_d;
      if (rsp_hs) txn_count <= txn_count + 16'd1;
    end
  end

endmodule
